// File: rtl/mandel_pkg.sv
// Shared types and fixed-point constants for the Mandelbrot escape-time engine.
// Default format is signed Q4.28 for c and z; full-precision squares are Q8.56.
// The MAX_ITER default here doubles as the "in set" result code.
package mandel_pkg;

    localparam int MANDEL_WIDTH    = 32;
    localparam int MANDEL_FRAC     = 28;
    localparam int MANDEL_MAX_ITER = 255;

    // Word-format constants (Q4.28)
    localparam logic signed [MANDEL_WIDTH-1:0] ONE_FX = 32'sd1 << MANDEL_FRAC;
    localparam logic signed [MANDEL_WIDTH-1:0] TWO_FX = 32'sd2 << MANDEL_FRAC;

    // Full-precision constants (Q8.56), for comparisons against squared magnitudes
    localparam logic [2*MANDEL_WIDTH-1:0] FOUR_FX      = 64'd4 << (2*MANDEL_FRAC);
    localparam logic [2*MANDEL_WIDTH-1:0] SIXTEENTH_FX = 64'd1 << (2*MANDEL_FRAC-4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mandel_sq_step.sv
// One z <- z^2 + c step plus the |z|^2 > 4 escape test, purely combinational.
// Latency: 0 cycles (no state).
// Backpressure: none; the caller decides when to register the result.
module mandel_sq_step
    import mandel_pkg::*;
#(
    parameter int WIDTH     = MANDEL_WIDTH,
    parameter int FRAC_BITS = MANDEL_FRAC
) (
    input  logic signed [WIDTH-1:0] zr_i,
    input  logic signed [WIDTH-1:0] zi_i,
    input  logic signed [WIDTH-1:0] c_re_i,
    input  logic signed [WIDTH-1:0] c_im_i,
    output logic signed [WIDTH-1:0] zr_o,
    output logic signed [WIDTH-1:0] zi_o,
    output logic                    esc_o
);

    // 4.0 scaled to the squared format; one extra bit so the sum of squares never wraps
    localparam logic [2*WIDTH:0] ESC_LIM = (2*WIDTH+1)'(1) << (2*FRAC_BITS + 2);

    logic signed [2*WIDTH-1:0] zr2;
    logic signed [2*WIDTH-1:0] zi2;
    logic        [2*WIDTH:0]   mag;

    assign zr2 = (2*WIDTH)'(zr_i) * (2*WIDTH)'(zr_i);
    assign zi2 = (2*WIDTH)'(zi_i) * (2*WIDTH)'(zi_i);

    // Squares are non-negative, so zero-extending keeps the sum exact
    assign mag   = {1'b0, zr2} + {1'b0, zi2};
    assign esc_o = (mag > ESC_LIM);

    // Products are truncated (not rounded) back to the word format; the cross
    // term takes its slice one bit lower to fold in the factor of two.
    assign zr_o = WIDTH'(zr2 >>> FRAC_BITS) - WIDTH'(zi2 >>> FRAC_BITS) + c_re_i;
    assign zi_o = WIDTH'(((2*WIDTH)'(zr_i) * (2*WIDTH)'(zi_i)) >>> (FRAC_BITS - 1)) + c_im_i;

endmodule

// File: rtl/mandel_iter_engine.sv
// Mandelbrot escape-time engine: one point at a time, one iteration per clock; optional MANDEL_BULB_SKIP_EN.
// Latency: out-of-range c (or bulb hit) -> DONE on the accept edge; else N+1 ITER cycles, MAX_ITER+1 for in-set.
// Backpressure: in_ready only in IDLE; out_ready low holds DONE with iteration stable, no same-cycle re-accept.
module mandel_iter_engine
    import mandel_pkg::*;
#(
    parameter int WIDTH     = MANDEL_WIDTH,
    parameter int FRAC_BITS = MANDEL_FRAC,
    parameter int MAX_ITER  = MANDEL_MAX_ITER
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] c_re,
    input  logic signed [WIDTH-1:0] c_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             iteration
);

    localparam int CNT_W = $clog2(MAX_ITER + 1);
    localparam logic signed [WIDTH-1:0] TWO_C = WIDTH'(2) << FRAC_BITS;

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] cre_q, cre_d, cim_q, cim_d;
    logic signed [WIDTH-1:0] zr_q, zr_d, zi_q, zi_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic        [31:0]      res_q, res_d;

    logic signed [WIDTH-1:0] zr_n, zi_n;
    logic                    esc;
    logic                    c_out_range;

    mandel_sq_step #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_step (
        .zr_i   (zr_q),
        .zi_i   (zi_q),
        .c_re_i (cre_q),
        .c_im_i (cim_q),
        .zr_o   (zr_n),
        .zi_o   (zi_n),
        .esc_o  (esc)
    );

    // Points outside the +/-2 square escape before the first iteration
    assign c_out_range = (c_re > TWO_C) || (c_re < -TWO_C) ||
                         (c_im > TWO_C) || (c_im < -TWO_C);

`ifdef MANDEL_BULB_SKIP_EN
    // Period-2 bulb: (c_re+1)^2 + c_im^2 < 1/16, evaluated at full precision
    localparam logic signed [WIDTH:0]   ONE_C       = (WIDTH+1)'(1) << FRAC_BITS;
    localparam logic        [2*WIDTH+2:0] SIXTEENTH_C = (2*WIDTH+3)'(1) << (2*FRAC_BITS - 4);

    logic signed [WIDTH:0]     bre;
    logic signed [2*WIDTH+1:0] bre2, bim2;
    logic        [2*WIDTH+2:0] bmag;
    logic                      bulb_hit;

    assign bre      = (WIDTH+1)'(c_re) + ONE_C;
    assign bre2     = (2*WIDTH+2)'(bre) * (2*WIDTH+2)'(bre);
    assign bim2     = (2*WIDTH+2)'(c_im) * (2*WIDTH+2)'(c_im);
    assign bmag     = {1'b0, bre2} + {1'b0, bim2};
    assign bulb_hit = (bmag < SIXTEENTH_C);
`endif

    // Handshake outputs decode straight from state so reset takes effect immediately
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign iteration = res_q;

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cre_d   = cre_q;
        cim_d   = cim_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cre_d = c_re;
                    cim_d = c_im;
                    zr_d  = '0;
                    zi_d  = '0;
                    cnt_d = '0;
                    if (c_out_range) begin
                        res_d   = '0;
                        state_d = DONE;
                    end
`ifdef MANDEL_BULB_SKIP_EN
                    else if (bulb_hit) begin
                        res_d   = 32'(MAX_ITER);
                        state_d = DONE;
                    end
`endif
                    else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                // Escape wins over the cap so a point escaping on the last step reports its count
                if (esc) begin
                    res_d   = 32'(cnt_q);
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(MAX_ITER)) begin
                    res_d   = 32'(MAX_ITER);
                    state_d = DONE;
                end else begin
                    zr_d  = zr_n;
                    zi_d  = zi_n;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cre_q   <= '0;
            cim_q   <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cre_q   <= cre_d;
            cim_q   <= cim_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_mandel_iter_engine.sv
// Directed bench for mandel_iter_engine with hand-computed escape counts and ITER-cycle latencies.
// Latency is counted as clock edges after the accept edge until out_valid is seen.
// Honors MANDEL_BULB_SKIP_EN for the bulb-point latency expectation.
module tb_mandel_iter_engine;
    import mandel_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] c_re;
    logic signed [31:0] c_im;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        iteration;

    int checks = 0;
    int passed = 0;

    localparam logic signed [31:0] ZERO_FX  = 32'sh0000_0000;
    localparam logic signed [31:0] HALF_FX  = 32'sh0800_0000;
    localparam logic signed [31:0] TWO5_FX  = 32'sh2800_0000;
    localparam logic signed [31:0] TWO25_FX = 32'sh2400_0000;

`ifdef MANDEL_BULB_SKIP_EN
    localparam int BULB_CYC = 0;
`else
    localparam int BULB_CYC = 256;
`endif

    mandel_iter_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_re      (c_re),
        .c_im      (c_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .iteration (iteration)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Present one point at a negedge; it is accepted on the following posedge
    task automatic issue(input string tag, input logic signed [31:0] re, input logic signed [31:0] im);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        c_re     = re;
        c_im     = im;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        c_re     = $urandom;
        c_im     = $urandom;
    endtask

    // Called just after an accept edge; counts edges until out_valid is seen
    task automatic wait_result(input string tag, input logic [31:0] exp_iter, input int exp_cyc);
        int cyc = 0;
        @(negedge clk);
        while (!out_valid && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_iter"}, iteration, exp_iter);
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
    endtask

    // Called at a negedge while out_valid is high
    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        c_re      = '0;
        c_im      = '0;

        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_iteration", iteration, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // z = 1, 2, 5 -> escapes with count 3
        issue("c1", ONE_FX, ZERO_FX);
        wait_result("c1", 32'd3, 4);
        take_result("c1");

        issue("c0", ZERO_FX, ZERO_FX);
        wait_result("c0", 32'd255, 256);
        take_result("c0");

        // |z|^2 sits exactly at 4: strict compare keeps it in the set
        issue("cm2", -TWO_FX, ZERO_FX);
        wait_result("cm2", 32'd255, 256);
        take_result("cm2");

        // Out of range: straight to DONE, then hold off the consumer
        issue("c25", TWO5_FX, ZERO_FX);
        wait_result("c25", 32'd0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_iter", iteration, 32'd0);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_valid", 32'(out_valid), 32'd1);
        end
        take_result("c25");

        issue("cm225", -TWO25_FX, ZERO_FX);
        wait_result("cm225", 32'd0, 0);
        take_result("cm225");

        issue("ci25", ZERO_FX, TWO5_FX);
        wait_result("ci25", 32'd0, 0);
        take_result("ci25");

        // z = -2i, then -4-2i escapes: count 2
        issue("cim2", ZERO_FX, -TWO_FX);
        wait_result("cim2", 32'd2, 3);
        take_result("cim2");

        // (.5,.5),(.5,1),(-.25,1.5),(-1.6875,-.25),(3.285..,..) -> count 5
        issue("chh", HALF_FX, HALF_FX);
        wait_result("chh", 32'd5, 6);
        take_result("chh");

        // c = 2.0 is in range: z = 2, 6 -> count 2; new point offered during the out_ready cycle
        issue("c2", TWO_FX, ZERO_FX);
        wait_result("c2", 32'd2, 3);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        c_re      = ONE_FX;
        c_im      = ZERO_FX;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("no_same_cycle_accept", 32'(in_ready), 32'd1);
        check("c2_drop_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        c_re     = $urandom;
        c_im     = $urandom;
        wait_result("reissue", 32'd3, 4);
        take_result("reissue");

        // Asynchronous reset in the middle of iterating
        issue("rst_mid", ZERO_FX, ZERO_FX);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_iteration", iteration, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_rst", ONE_FX, ZERO_FX);
        wait_result("post_rst", 32'd3, 4);
        take_result("post_rst");

        // Period-2 bulb centre
        issue("bulb", -ONE_FX, ZERO_FX);
        wait_result("bulb", 32'd255, BULB_CYC);
        take_result("bulb");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
